// File: rtl/hermes_buffer_pkg.sv
// Shared Hermes router types: port enumeration, default flit width and the
// input-buffer framing states.
package hermes_buffer_pkg;

  localparam int HERMES_NPORT     = 5;
  localparam int HERMES_FLIT_SIZE = 32;

  typedef enum logic [2:0] {
    HERMES_EAST,
    HERMES_WEST,
    HERMES_NORTH,
    HERMES_SOUTH,
    HERMES_LOCAL
  } hermes_port_t;

  typedef enum logic [1:0] {
    HERMES_BUF_HEADER,
    HERMES_BUF_SEND_HEADER,
    HERMES_BUF_SIZE,
    HERMES_BUF_PAYLOAD
  } hermes_buffer_state_t;

endpackage

// File: rtl/hermes_fifo.sv
// Circular flit store for one router input: power-of-two depth, naturally
// wrapping pointers and an occupancy counter one bit wider than the pointers.
module hermes_fifo #(
  parameter int FLIT_SIZE   = 32,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_i,
  input  logic [FLIT_SIZE-1:0] wr_data_i,
  input  logic                 rd_i,
  output logic [FLIT_SIZE-1:0] rd_data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);

  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [PTR_W:0]       count;
  logic [FLIT_SIZE-1:0] mem [BUFFER_SIZE];
  logic                 wr_en;
  logic                 rd_en;

  // A read from full never frees a slot for the same-cycle write.
  assign wr_en     = wr_i && !full_o;
  assign rd_en     = rd_i && !empty_o;
  assign full_o    = (count == (PTR_W+1)'(BUFFER_SIZE));
  assign empty_o   = (count == '0);
  assign rd_data_o = mem[head];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en) tail <= tail + 1'b1;
      if (rd_en) head <= head + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[tail] <= wr_data_i;
  end

endmodule

// File: rtl/hermes_buffer.sv
// Hermes router input buffer: flit FIFO with credit flow control plus the
// header/size/payload framing FSM that forwards one packet per routing grant.
module hermes_buffer
  import hermes_buffer_pkg::*;
#(
  parameter int FLIT_SIZE   = HERMES_FLIT_SIZE,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic                 credit_o,
  output logic                 req_routing_o,
  input  logic                 ack_routing_i,
  output logic                 sending_o,
  output logic                 data_av_o,
  output logic [FLIT_SIZE-1:0] data_o,
  input  logic                 credit_i,
  output hermes_buffer_state_t state_o
);

  // Handshakes: a flit moves upstream->buffer when rx_i && credit_o and
  // buffer->crossbar when data_av_o && credit_i, both at the rising edge;
  // neither side may make its offer depend on the other side's acceptance.
  hermes_buffer_state_t state, state_nxt;
  logic [FLIT_SIZE-1:0] payload_cnt, payload_cnt_nxt;
  logic                 full;
  logic                 empty;
  logic                 rd;

  hermes_fifo #(
    .FLIT_SIZE   (FLIT_SIZE),
    .BUFFER_SIZE (BUFFER_SIZE)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_i      (rx_i),
    .wr_data_i (data_i),
    .rd_i      (rd),
    .rd_data_o (data_o),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign credit_o = !full;
  assign rd       = data_av_o && credit_i;
  assign state_o  = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= HERMES_BUF_HEADER;
      payload_cnt <= '0;
    end else begin
      state       <= state_nxt;
      payload_cnt <= payload_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    payload_cnt_nxt = payload_cnt;
    case (state)
      HERMES_BUF_HEADER: begin
        if (ack_routing_i && !empty) state_nxt = HERMES_BUF_SEND_HEADER;
      end
      HERMES_BUF_SEND_HEADER: begin
        if (rd) state_nxt = HERMES_BUF_SIZE;
      end
      HERMES_BUF_SIZE: begin
        if (rd) begin
          payload_cnt_nxt = data_o;
          state_nxt = (data_o == '0) ? HERMES_BUF_HEADER : HERMES_BUF_PAYLOAD;
        end
      end
      HERMES_BUF_PAYLOAD: begin
        if (rd) begin
          payload_cnt_nxt = payload_cnt - 1'b1;
          if (payload_cnt == FLIT_SIZE'(1)) state_nxt = HERMES_BUF_HEADER;
        end
      end
      default: state_nxt = HERMES_BUF_HEADER;
    endcase
  end

  always_comb begin
    req_routing_o = (state == HERMES_BUF_HEADER) && !empty;
    sending_o     = (state != HERMES_BUF_HEADER);
    data_av_o     = sending_o && !empty;
  end

endmodule

// File: tb/tb_hermes_buffer.sv
// Directed and scoreboarded checks of hermes_buffer at depth 8 (dut) and
// depth 4 (dut4) for fill, wrap-around and the small-buffer corner cases.
module tb_hermes_buffer;
  import hermes_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic rx = 0, ack = 0, credit_in = 0;
  logic [31:0] data_in = '0;
  logic credit_out, req, sending, data_av;
  logic [31:0] data_out;
  hermes_buffer_state_t state;

  logic rx4 = 0, ack4 = 0, credit_in4 = 0;
  logic [31:0] data_in4 = '0;
  logic credit_out4, req4, sending4, data_av4;
  logic [31:0] data_out4;
  hermes_buffer_state_t state4;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] f[$];
  logic [31:0] stim[$];
  logic [31:0] exp_q[$];

  hermes_buffer #(.FLIT_SIZE(32), .BUFFER_SIZE(8)) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx), .data_i(data_in), .credit_o(credit_out),
    .req_routing_o(req), .ack_routing_i(ack), .sending_o(sending), .data_av_o(data_av),
    .data_o(data_out), .credit_i(credit_in), .state_o(state));

  hermes_buffer #(.FLIT_SIZE(32), .BUFFER_SIZE(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .rx_i(rx4), .data_i(data_in4), .credit_o(credit_out4),
    .req_routing_o(req4), .ack_routing_i(ack4), .sending_o(sending4), .data_av_o(data_av4),
    .data_o(data_out4), .credit_i(credit_in4), .state_o(state4));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic write_flit(input logic [31:0] v);
    rx = 1'b1; data_in = v; step(); rx = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    n_checks++; if (credit_out !== 1'b1) begin n_fail++; $display("FAIL reset_credit: got %b want 1", credit_out); end
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", req); end
    n_checks++; if (sending !== 1'b0) begin n_fail++; $display("FAIL reset_sending: got %b want 0", sending); end
    n_checks++; if (data_av !== 1'b0) begin n_fail++; $display("FAIL reset_data_av: got %b want 0", data_av); end
    n_checks++; if (state !== HERMES_BUF_HEADER) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_checks++; if (credit_out4 !== 1'b1) begin n_fail++; $display("FAIL reset_credit4: got %b want 1", credit_out4); end
    rst = 1'b0; step();
  endtask

  task automatic test_basic_packet();
    f = '{32'h0000_0101, 32'd3, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    credit_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      write_flit(f[i]);
      if (i == 0) begin
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL basic_req_latency: got %b want 1", req); end
      end
    end
    n_checks++; if (sending !== 1'b0) begin n_fail++; $display("FAIL basic_not_sending: got %b want 0", sending); end
    pulse_ack();
    n_checks++; if (sending !== 1'b1) begin n_fail++; $display("FAIL basic_sending_after_ack: got %b want 1", sending); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (data_av !== 1'b1) begin n_fail++; $display("FAIL basic_data_av[%0d]: got %b want 1", i, data_av); end
      n_checks++; if (data_out !== f[i]) begin n_fail++; $display("FAIL basic_data[%0d]: got %h want %h", i, data_out, f[i]); end
      step();
    end
    n_checks++; if (sending !== 1'b0) begin n_fail++; $display("FAIL basic_end_sending: got %b want 0", sending); end
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL basic_end_req: got %b want 0", req); end
    n_checks++; if (data_av !== 1'b0) begin n_fail++; $display("FAIL basic_end_data_av: got %b want 0", data_av); end
  endtask

  task automatic test_size_zero();
    write_flit(32'h0000_0202);
    write_flit(32'd0);
    pulse_ack();
    n_checks++; if (data_out !== 32'h0000_0202) begin n_fail++; $display("FAIL size0_header: got %h want 00000202", data_out); end
    n_checks++; if (state !== HERMES_BUF_SEND_HEADER) begin n_fail++; $display("FAIL size0_state_sh: got %0d want 1", state); end
    step();
    n_checks++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL size0_size: got %h want 0", data_out); end
    n_checks++; if (state !== HERMES_BUF_SIZE) begin n_fail++; $display("FAIL size0_state_size: got %0d want 2", state); end
    step();
    n_checks++; if (sending !== 1'b0) begin n_fail++; $display("FAIL size0_sending: got %b want 0", sending); end
    n_checks++; if (state !== HERMES_BUF_HEADER) begin n_fail++; $display("FAIL size0_state_hdr: got %0d want 0", state); end
  endtask

  task automatic test_back_to_back();
    f = '{32'h0000_0303, 32'd2, 32'h1111_0001, 32'h1111_0002,
          32'h0000_0404, 32'd2, 32'h2222_0001, 32'h2222_0002};
    for (int i = 0; i < 8; i++) begin
      rx = 1'b1; data_in = f[i]; step();
    end
    rx = 1'b0;
    n_checks++; if (credit_out !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got %b want 0", credit_out); end
    pulse_ack();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (data_out !== f[i]) begin n_fail++; $display("FAIL b2b_pkt1[%0d]: got %h want %h", i, data_out, f[i]); end
      step();
    end
    n_checks++; if (sending !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_sending: got %b want 0", sending); end
    n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL b2b_second_req: got %b want 1", req); end
    n_checks++; if (data_out !== f[4]) begin n_fail++; $display("FAIL b2b_second_head: got %h want %h", data_out, f[4]); end
    pulse_ack();
    for (int i = 4; i < 8; i++) begin
      n_checks++; if (data_out !== f[i]) begin n_fail++; $display("FAIL b2b_pkt2[%0d]: got %h want %h", i, data_out, f[i]); end
      step();
    end
    n_checks++; if (req !== 1'b0 || sending !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got req=%b sending=%b want 0 0", req, sending); end
  endtask

  task automatic test_ack_empty();
    pulse_ack();
    n_checks++; if (sending !== 1'b0) begin n_fail++; $display("FAIL ack_empty_sending: got %b want 0", sending); end
    n_checks++; if (state !== HERMES_BUF_HEADER) begin n_fail++; $display("FAIL ack_empty_state: got %0d want 0", state); end
    step();
    n_checks++; if (sending !== 1'b0) begin n_fail++; $display("FAIL ack_empty_later: got %b want 0", sending); end
  endtask

  task automatic test_reset_mid_packet();
    f = '{32'h0000_0505, 32'd5, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9};
    for (int i = 0; i < 7; i++) write_flit(f[i]);
    pulse_ack();
    repeat (4) step();
    n_checks++; if (state !== HERMES_BUF_PAYLOAD) begin n_fail++; $display("FAIL mid_state_payload: got %0d want 3", state); end
    rst = 1'b1; #1;
    n_checks++; if (credit_out !== 1'b1) begin n_fail++; $display("FAIL mid_rst_credit: got %b want 1", credit_out); end
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req: got %b want 0", req); end
    n_checks++; if (sending !== 1'b0) begin n_fail++; $display("FAIL mid_rst_sending: got %b want 0", sending); end
    n_checks++; if (data_av !== 1'b0) begin n_fail++; $display("FAIL mid_rst_data_av: got %b want 0", data_av); end
    n_checks++; if (state !== HERMES_BUF_HEADER) begin n_fail++; $display("FAIL mid_rst_state: got %0d want 0", state); end
    step(); rst = 1'b0; step();
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL mid_flushed: got req=%b want 0", req); end
    write_flit(32'h0000_0606);
    write_flit(32'd0);
    pulse_ack();
    n_checks++; if (data_out !== 32'h0000_0606) begin n_fail++; $display("FAIL mid_new_head: got %h want 00000606", data_out); end
    step(); step();
    n_checks++; if (sending !== 1'b0) begin n_fail++; $display("FAIL mid_drain: got %b want 0", sending); end
  endtask

  task automatic test_full_wrap();
    int cycles;
    int idx;
    logic wr, rd;
    f = '{32'h0000_0707, 32'd6, 32'h7000_0001, 32'h7000_0002};
    credit_in4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx4 = 1'b1; data_in4 = f[i]; step();
    end
    n_checks++; if (credit_out4 !== 1'b0) begin n_fail++; $display("FAIL full_credit_low: got %b want 0", credit_out4); end
    data_in4 = 32'hDEAD_BEEF; step(); rx4 = 1'b0;
    n_checks++; if (credit_out4 !== 1'b0) begin n_fail++; $display("FAIL full_fifth_ignored: got %b want 0", credit_out4); end
    ack4 = 1'b1; step(); ack4 = 1'b0;
    step(); step();
    n_checks++; if (data_out4 !== 32'h0000_0707) begin n_fail++; $display("FAIL full_hold_head: got %h want 00000707", data_out4); end
    n_checks++; if (state4 !== HERMES_BUF_SEND_HEADER) begin n_fail++; $display("FAIL full_hold_state: got %0d want 1", state4); end
    credit_in4 = 1'b1; step();
    n_checks++; if (credit_out4 !== 1'b1) begin n_fail++; $display("FAIL full_credit_rise: got %b want 1", credit_out4); end
    exp_q = '{32'd6, 32'h7000_0001, 32'h7000_0002};
    stim = '{32'h7000_0003, 32'h7000_0004, 32'h7000_0005, 32'h7000_0006,
             32'h0000_0808, 32'd4, 32'h8000_0001, 32'h8000_0002, 32'h8000_0003, 32'h8000_0004,
             32'h0000_0909, 32'd2, 32'h9000_0001, 32'h9000_0002};
    idx = 0; cycles = 0;
    while ((idx < stim.size() || exp_q.size() > 0) && cycles < 500) begin
      rx4 = (idx < stim.size());
      data_in4 = rx4 ? stim[idx] : 32'h0;
      #1; ack4 = req4; #1;
      wr = rx4 && credit_out4;
      rd = data_av4 && credit_in4;
      if (rd) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL wrap_unexpected: got %h want none", data_out4); end
        else begin
          if (data_out4 !== exp_q[0]) begin n_fail++; $display("FAIL wrap_data: got %h want %h", data_out4, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      if (wr) begin exp_q.push_back(stim[idx]); idx++; end
      @(posedge clk); #1; cycles++;
    end
    rx4 = 1'b0; ack4 = 1'b0;
    n_checks++; if (cycles >= 500) begin n_fail++; $display("FAIL wrap_timeout: got %0d cycles want <500", cycles); end
    n_checks++; if (sending4 !== 1'b0) begin n_fail++; $display("FAIL wrap_end_sending: got %b want 0", sending4); end
  endtask

  task automatic test_random_stream();
    int cycles;
    int idx;
    int occ;
    int pkt;
    int sz;
    logic wr, rd;
    stim.delete(); exp_q.delete();
    pkt = 0;
    while (stim.size() < 1000) begin
      sz = $urandom_range(0, 4);
      stim.push_back(32'hA000_0000 | 32'(pkt));
      stim.push_back(32'(sz));
      for (int k = 0; k < sz; k++) stim.push_back($urandom);
      pkt++;
    end
    idx = 0; cycles = 0; occ = 0;
    while ((idx < stim.size() || exp_q.size() > 0) && cycles < 20000) begin
      rx = (idx < stim.size()) && ($urandom_range(0, 1) == 1);
      data_in = (idx < stim.size()) ? stim[idx] : 32'h0;
      credit_in = ($urandom_range(0, 1) == 1);
      #1; ack = req; #1;
      n_checks++;
      if (credit_out !== (occ != 8)) begin n_fail++; $display("FAIL rand_credit: got %b want %b (occ %0d)", credit_out, occ != 8, occ); end
      wr = rx && credit_out;
      rd = data_av && credit_in;
      if (rd) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand_unexpected: got %h want none", data_out); end
        else begin
          if (data_out !== exp_q[0]) begin n_fail++; $display("FAIL rand_data: got %h want %h", data_out, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      if (wr) begin exp_q.push_back(stim[idx]); idx++; end
      occ = occ + (wr ? 1 : 0) - (rd ? 1 : 0);
      @(posedge clk); #1; cycles++;
    end
    rx = 1'b0; ack = 1'b0;
    n_checks++; if (cycles >= 20000) begin n_fail++; $display("FAIL rand_timeout: got %0d cycles want <20000", cycles); end
    n_checks++; if (sending !== 1'b0) begin n_fail++; $display("FAIL rand_end_sending: got %b want 0", sending); end
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_size_zero();
    test_back_to_back();
    test_ack_empty();
    test_reset_mid_packet();
    test_full_wrap();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
